// File: rtl/demultiplexer_if.sv
// Streaming bus bundle for the demultiplexer: one sink port, two source ports, drop counter.
interface demultiplexer_if #(
    parameter int data_width    = 128,
    parameter int empty_width   = 2,
    parameter int channel_width = 1
);
    logic [channel_width-1:0] avsi_channel;
    logic [data_width-1:0]    avsi_data;
    logic                     avsi_sop;
    logic                     avsi_eop;
    logic [empty_width-1:0]   avsi_empty;
    logic                     avsi_valid;
    logic                     avsi_ready;

    logic [channel_width-1:0] avso_one_channel;
    logic [data_width-1:0]    avso_one_data;
    logic                     avso_one_valid;
    logic                     avso_one_sop;
    logic                     avso_one_eop;
    logic [empty_width-1:0]   avso_one_empty;
    logic                     avso_one_ready;

    logic [channel_width-1:0] avso_two_channel;
    logic [data_width-1:0]    avso_two_data;
    logic                     avso_two_valid;
    logic                     avso_two_sop;
    logic                     avso_two_eop;
    logic [empty_width-1:0]   avso_two_empty;
    logic                     avso_two_ready;

    logic [15:0]              drop_count;

    modport slave (
        input  avsi_channel, avsi_data, avsi_sop, avsi_eop, avsi_empty, avsi_valid,
        output avsi_ready,
        output avso_one_channel, avso_one_data, avso_one_valid, avso_one_sop, avso_one_eop, avso_one_empty,
        input  avso_one_ready,
        output avso_two_channel, avso_two_data, avso_two_valid, avso_two_sop, avso_two_eop, avso_two_empty,
        input  avso_two_ready,
        output drop_count
    );

    modport master (
        output avsi_channel, avsi_data, avsi_sop, avsi_eop, avsi_empty, avsi_valid,
        input  avsi_ready,
        input  avso_one_channel, avso_one_data, avso_one_valid, avso_one_sop, avso_one_eop, avso_one_empty,
        output avso_one_ready,
        input  avso_two_channel, avso_two_data, avso_two_valid, avso_two_sop, avso_two_eop, avso_two_empty,
        output avso_two_ready,
        input  drop_count
    );
endinterface

// File: rtl/demultiplexer.sv
// Packet demultiplexer: routes each sop-decoded packet to output one, output two, or drops it.
// Define DEMUX_OUTPUT_REG_EN to add a one-entry register stage on each output.
module demultiplexer #(
    parameter int data_width     = 128,
    parameter int empty_width    = 2,
    parameter int channel_width  = 1,
    parameter int one_channel_id = 0,
    parameter int two_channel_id = 1
) (
    input  logic            clk,
    input  logic            reset,
    demultiplexer_if.slave  bus
);
    localparam int BEAT_W = channel_width + data_width + 2 + empty_width;
    localparam logic [channel_width-1:0] ONE_ID = channel_width'(one_channel_id);
    localparam logic [channel_width-1:0] TWO_ID = channel_width'(two_channel_id);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ROUTE_ONE = 2'd1;
    localparam logic [1:0] ROUTE_TWO = 2'd2;
    localparam logic [1:0] DROP      = 2'd3;

    logic [1:0]               state_q, state_d, route;
    logic                     head_vld_q, head_vld_d;
    logic [BEAT_W-1:0]        head_q, in_beat;
    logic [channel_width-1:0] head_ch;
    logic                     head_sop, head_eop;
    logic [15:0]              drop_q, drop_d;
    logic                     accept_one, accept_two;
    logic                     take_one, take_two, take_drop, consume;
    logic                     in_rdy, in_xfer;
    logic                     one_vld, two_vld;
    logic [BEAT_W-1:0]        one_beat, two_beat;

    assign in_beat  = {bus.avsi_channel, bus.avsi_data, bus.avsi_sop, bus.avsi_eop, bus.avsi_empty};
    assign head_ch  = head_q[BEAT_W-1 -: channel_width];
    assign head_sop = head_q[empty_width+1];
    assign head_eop = head_q[empty_width];

    // Mid-packet beats follow the packet's route; only IDLE looks at sop/channel.
    always_comb begin
        route = state_q;
        if (state_q == IDLE) begin
            if (!head_sop)            route = DROP;
            else if (head_ch == ONE_ID) route = ROUTE_ONE;
            else if (head_ch == TWO_ID) route = ROUTE_TWO;
            else                      route = DROP;
        end
    end

    assign take_one  = head_vld_q && (route == ROUTE_ONE) && accept_one;
    assign take_two  = head_vld_q && (route == ROUTE_TWO) && accept_two;
    assign take_drop = head_vld_q && (route == DROP);
    assign consume   = take_one || take_two || take_drop;

    assign in_rdy         = !reset && (!head_vld_q || consume);
    assign in_xfer        = bus.avsi_valid && in_rdy;
    assign bus.avsi_ready = in_rdy;

    assign head_vld_d = in_xfer || (head_vld_q && !consume);
    assign state_d    = consume ? (head_eop ? IDLE : route) : state_q;
    assign drop_d     = (take_drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            head_vld_q <= 1'b0;
            drop_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            head_vld_q <= head_vld_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) head_q <= in_beat;
    end

`ifdef DEMUX_OUTPUT_REG_EN
    logic              one_vld_q, two_vld_q;
    logic [BEAT_W-1:0] one_q, two_q;

    // Each stage refills independently, so a stall on one side never holds the other.
    assign accept_one = !one_vld_q || bus.avso_one_ready;
    assign accept_two = !two_vld_q || bus.avso_two_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            one_vld_q <= 1'b0;
            two_vld_q <= 1'b0;
        end else begin
            if (accept_one) one_vld_q <= take_one;
            if (accept_two) two_vld_q <= take_two;
        end
    end

    always_ff @(posedge clk) begin
        if (take_one) one_q <= head_q;
        if (take_two) two_q <= head_q;
    end

    assign one_vld  = one_vld_q;
    assign two_vld  = two_vld_q;
    assign one_beat = one_q;
    assign two_beat = two_q;
`else
    assign accept_one = bus.avso_one_ready;
    assign accept_two = bus.avso_two_ready;
    assign one_vld    = head_vld_q && (route == ROUTE_ONE);
    assign two_vld    = head_vld_q && (route == ROUTE_TWO);
    assign one_beat   = one_vld ? head_q : '0;
    assign two_beat   = two_vld ? head_q : '0;
`endif

    assign bus.avso_one_valid = one_vld;
    assign bus.avso_two_valid = two_vld;
    assign {bus.avso_one_channel, bus.avso_one_data, bus.avso_one_sop,
            bus.avso_one_eop, bus.avso_one_empty} = one_beat;
    assign {bus.avso_two_channel, bus.avso_two_data, bus.avso_two_sop,
            bus.avso_two_eop, bus.avso_two_empty} = two_beat;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_demultiplexer.sv
// Self-checking bench for demultiplexer: packet-level reference model, directed and random traffic.
module tb_demultiplexer;
    localparam int DW = 32, EW = 2, CW = 2, ONE_ID = 0, TWO_ID = 1;
`ifdef DEMUX_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    demultiplexer_if #(.data_width(DW), .empty_width(EW), .channel_width(CW)) bus ();

    demultiplexer #(
        .data_width(DW), .empty_width(EW), .channel_width(CW),
        .one_channel_id(ONE_ID), .two_channel_id(TWO_ID)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int rdy_mode = 0, pidx = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit lat_en = 0;
    int stall_tot = 0, stall_two = 0;

    // Reference model: expected beats per output and expected drop total.
    beat_t q1[$], q2[$], obs1[$], obs2[$];
    int    t1[$], t2[$];
    bit    m_in_pkt = 0;
    int    m_route = 0;
    int    m_drops = 0;

    bit    prev1_stall = 0, prev2_stall = 0;
    beat_t prev1, prev2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_in(input beat_t b, input int now);
        if (!m_in_pkt) begin
            if (!b.sop)                    m_route = 3;
            else if (b.ch == CW'(ONE_ID))  m_route = 1;
            else if (b.ch == CW'(TWO_ID))  m_route = 2;
            else                           m_route = 3;
        end
        if (m_route == 1)      begin q1.push_back(b); t1.push_back(now); end
        else if (m_route == 2) begin q2.push_back(b); t2.push_back(now); end
        else if (m_drops < 65535) m_drops++;
        m_in_pkt = !b.eop;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: begin bus.avso_one_ready = 1'b1; bus.avso_two_ready = 1'b1; end
            1: begin bus.avso_one_ready = ($urandom_range(0, 3) != 0); bus.avso_two_ready = ($urandom_range(0, 2) != 0); end
            default: begin
                bus.avso_one_ready = 1'b1;
                bus.avso_two_ready = (pidx < 4) ? pat[pidx] : 1'b1;
                pidx++;
            end
        endcase
    end

    always @(negedge clk) begin
        beat_t g1, g2, e;
        cyc++;
        g1 = {bus.avso_one_channel, bus.avso_one_data, bus.avso_one_sop, bus.avso_one_eop, bus.avso_one_empty};
        g2 = {bus.avso_two_channel, bus.avso_two_data, bus.avso_two_sop, bus.avso_two_eop, bus.avso_two_empty};
        if (reset) begin
            chk("rst_one_valid", bus.avso_one_valid, 0);
            chk("rst_two_valid", bus.avso_two_valid, 0);
            chk("rst_ready", bus.avsi_ready, 0);
            chk("rst_drop_count", bus.drop_count, 0);
            q1.delete(); q2.delete(); t1.delete(); t2.delete();
            m_in_pkt = 0; m_drops = 0;
            prev1_stall = 0; prev2_stall = 0;
        end else begin
            if (prev1_stall) begin
                chk("one_hold_valid", bus.avso_one_valid, 1);
                chk("one_hold_fields", g1, prev1);
            end
            if (prev2_stall) begin
                chk("two_hold_valid", bus.avso_two_valid, 1);
                chk("two_hold_fields", g2, prev2);
            end
            prev1_stall = bus.avso_one_valid && !bus.avso_one_ready;
            prev2_stall = bus.avso_two_valid && !bus.avso_two_ready;
            prev1 = g1; prev2 = g2;
            if (prev2_stall) stall_two++;
`ifndef DEMUX_OUTPUT_REG_EN
            if (prev1_stall || prev2_stall) chk("ready_low_when_blocked", bus.avsi_ready, 0);
`endif
            if (bus.avso_one_valid && bus.avso_one_ready) begin
                obs1.push_back(g1);
                if (q1.size() == 0) chk("one_unexpected_beat", g1, 64'hDEAD);
                else begin
                    e = q1.pop_front();
                    chk("one_beat", g1, e);
                    if (lat_en) chk("one_latency", 64'(cyc - t1[0]), 64'(LAT));
                    void'(t1.pop_front());
                end
            end
            if (bus.avso_two_valid && bus.avso_two_ready) begin
                obs2.push_back(g2);
                if (q2.size() == 0) chk("two_unexpected_beat", g2, 64'hDEAD);
                else begin
                    e = q2.pop_front();
                    chk("two_beat", g2, e);
                    if (lat_en) chk("two_latency", 64'(cyc - t2[0]), 64'(LAT));
                    void'(t2.pop_front());
                end
            end
            if (bus.avsi_valid && bus.avsi_ready)
                model_in({bus.avsi_channel, bus.avsi_data, bus.avsi_sop, bus.avsi_eop, bus.avsi_empty}, cyc);
        end
    end

    task automatic idle(input int n);
        bus.avsi_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input beat_t b);
        int waited;
        waited = 0;
        {bus.avsi_channel, bus.avsi_data, bus.avsi_sop, bus.avsi_eop, bus.avsi_empty} = b;
        bus.avsi_valid = 1'b1;
        @(negedge clk);
        while (!bus.avsi_ready) begin
            waited++;
            if (waited > 200) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout: got ready=0 for %0d cycles expected 1", waited);
                break;
            end
            @(negedge clk);
        end
        stall_tot += waited;
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(input int ch, input int data, input bit sop, input bit eop, input int empty);
        beat_t b;
        b.ch = CW'(ch); b.data = DW'(data); b.sop = sop; b.eop = eop; b.empty = EW'(empty);
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.avsi_valid = 1'b0;
        {bus.avsi_channel, bus.avsi_data, bus.avsi_sop, bus.avsi_eop, bus.avsi_empty} = '0;
        bus.avso_one_ready = 1'b1; bus.avso_two_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.avsi_ready, 1);
        @(posedge clk); #1;

        // 4-beat packet on channel 0
        obs1.delete(); obs2.delete(); lat_en = 1;
        for (int i = 0; i < 4; i++) send(mk(0, 'h1000 + i, i == 0, i == 3, (i == 3) ? 2 : 0));
        idle(6);
        chk("s1_count_one", obs1.size(), 4);
        chk("s1_count_two", obs2.size(), 0);
        if (obs1.size() == 4) begin
            chk("s1_first_sop", obs1[0].sop, 1);
            chk("s1_first_data", obs1[0].data, 'h1000);
            chk("s1_last_eop", obs1[3].eop, 1);
            chk("s1_last_empty", obs1[3].empty, 2);
            chk("s1_last_data", obs1[3].data, 'h1003);
        end

        // single-beat on channel 1 then 3-beat on channel 0, back to back
        obs1.delete(); obs2.delete(); stall_tot = 0;
        send(mk(1, 'hA0, 1, 1, 1));
        for (int i = 0; i < 3; i++) send(mk(0, 'hB0 + i, i == 0, i == 2, 0));
        idle(6);
        lat_en = 0;
        chk("s2_input_stalls", stall_tot, 0);
        chk("s2_count_two", obs2.size(), 1);
        chk("s2_count_one", obs1.size(), 3);
        if (obs1.size() == 3) chk("s2_one_last_data", obs1[2].data, 'hB2);
        if (obs2.size() == 1) chk("s2_two_data", obs2[0].data, 'hA0);

        // 3-beat on channel 1 with output two ready pattern 1,0,0,1
        obs1.delete(); obs2.delete(); stall_two = 0;
        pidx = 0; rdy_mode = 2;
        for (int i = 0; i < 3; i++) send(mk(1, 'hC0 + i, i == 0, i == 2, 0));
        idle(10);
        rdy_mode = 0;
        chk("s3_stall_seen", stall_two > 0, 1);
        chk("s3_count_two", obs2.size(), 3);
        if (obs2.size() == 3) chk("s3_last_data", obs2[2].data, 'hC2);

        // orphan beat, then a packet on unmapped channel 3
        obs1.delete(); obs2.delete();
        send(mk(0, 'hD0, 0, 1, 0));
        send(mk(3, 'hD1, 1, 0, 0));
        send(mk(3, 'hD2, 0, 1, 0));
        idle(5);
        chk("s4_drop_count", bus.drop_count, 3);
        chk("s4_drop_model", bus.drop_count, 16'(m_drops));
        chk("s4_no_output", obs1.size() + obs2.size(), 0);

        // reset in the middle of a 5-beat packet
        for (int i = 0; i < 2; i++) send(mk(0, 'hE0 + i, i == 0, 0, 0));
        bus.avsi_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("s5_rst_one_valid", bus.avso_one_valid, 0);
        chk("s5_rst_drop", bus.drop_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        obs1.delete(); obs2.delete();
        send(mk(1, 'hF0, 1, 0, 0));
        send(mk(1, 'hF1, 0, 1, 3));
        idle(6);
        chk("s5_count_two", obs2.size(), 2);
        chk("s5_count_one", obs1.size(), 0);
        if (obs2.size() == 2) chk("s5_two_last", obs2[1], mk(1, 'hF1, 0, 1, 3));

        // random traffic with random backpressure
        rdy_mode = 1;
        for (int p = 0; p < 120; p++) begin
            int len, ch;
            bit first_sop;
            len = $urandom_range(1, 4);
            ch = $urandom_range(0, 3);
            first_sop = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < len; i++) begin
                send(mk(ch, $urandom, (i == 0) ? first_sop : ($urandom_range(0, 7) == 0),
                        i == len - 1, $urandom_range(0, 3)));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        rdy_mode = 0;
        idle(20);
        chk("rand_q1_drained", q1.size(), 0);
        chk("rand_q2_drained", q2.size(), 0);
        chk("rand_drop_count", bus.drop_count, 16'(m_drops));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/demultiplexer.md
DEMULTIPLEXER -- requirements
Module: demultiplexer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameters SHALL be (name, default, meaning):
- data_width, 128, data bus width
- empty_width, 2, empty field width
- channel_width, 1, channel field width
- one_channel_id, 0, channel value routed to output one
- two_channel_id, 1, channel value routed to output two
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, async active-high reset
- avsi_channel/data/sop/eop/empty, in, channel_width/data_width/1/1/empty_width, input beat fields
- avsi_valid, in, 1, input beat valid
- avsi_ready, out, 1, input beat accepted when high with avsi_valid
- avso_one_channel/data/valid/sop/eop/empty, out, as input, output one beat fields
- avso_one_ready, in, 1, output one sink ready
- avso_two_channel/data/valid/sop/eop/empty, out, as input, output two beat fields
- avso_two_ready, in, 1, output two sink ready
- drop_count, out, 16, saturating count of dropped beats

Function
REQ-004 An input beat SHALL transfer when avsi_valid and avsi_ready are both high on a clk edge; it enters a one-entry head register.
REQ-005 avsi_ready SHALL equal (head empty) OR (head beat transfers or is dropped this cycle); back-to-back transfers SHALL sustain one beat per cycle.
REQ-006 FSM states SHALL be IDLE, ROUTE_ONE, ROUTE_TWO, DROP.
REQ-007 In IDLE, the route SHALL be decoded combinationally from the head beat: sop with channel==one_channel_id -> one; sop with channel==two_channel_id -> two; sop with any other channel -> drop; no sop -> drop (orphan beat).
REQ-008 In ROUTE_ONE/ROUTE_TWO/DROP, the route SHALL be the state itself; head channel is ignored for mid-packet beats.
REQ-009 A routed head beat SHALL be presented to the selected output and leave the head when that output stage can accept it; the other output SHALL not see it.
REQ-010 A dropped head beat SHALL leave the head in the same cycle it is valid and increment drop_count, saturating at 16'hFFFF.
REQ-011 State SHALL advance on head beat consumption: eop beat -> IDLE; non-eop beat -> ROUTE_ONE/ROUTE_TWO/DROP per current route; single-beat packet (sop and eop) -> IDLE with no idle bubble.
REQ-012 A sop beat arriving mid-packet in ROUTE_ONE/ROUTE_TWO SHALL be forwarded as data on the current route; no re-decode.
REQ-013 Channel, data, sop, eop, empty SHALL be forwarded unmodified to the selected output.
REQ-014 A stalled output SHALL hold all its fields stable while its valid is high and ready low.
REQ-015 Latency from input transfer to output valid SHALL be 1 cycle without DEMUX_OUTPUT_REG_EN, 2 cycles with it, given ready outputs.

Reset
REQ-016 While reset is high: state=IDLE, head empty, avsi_ready=0, avso_one_valid=0, avso_two_valid=0, drop_count=0; data fields are don't-care.
REQ-017 Reset asserted mid-packet SHALL discard the partial packet; after release the next beat is decoded in IDLE.
REQ-018 avsi_ready SHALL rise in the first cycle after reset deassertion.

Configuration
REQ-019 Macro DEMUX_OUTPUT_REG_EN defined: each output SHALL have its own one-entry register stage (accepts when empty or its ready high); one output stalling SHALL not block a packet already in the other output stage.
REQ-020 Macro DEMUX_OUTPUT_REG_EN undefined: outputs SHALL be driven combinationally from the head register, gated by route; avsi_ready SHALL depend combinationally on the selected avso_*_ready.

Verification
REQ-021 4-beat packet channel 0, both readies high -> 4 beats on output one in order, sop on beat 1, eop+empty on beat 4, output two valid never high.
REQ-022 Single-beat packet channel 1 immediately followed by 3-beat packet channel 0 -> one beat on output two, then 3 beats on output one, no idle cycle at input.
REQ-023 3-beat packet channel 1 with avso_two_ready toggling 1,0,0,1 -> output fields stable during stall, avsi_ready low while head is blocked, no beats lost.
REQ-024 Orphan beat (no sop) in IDLE, then 2-beat packet with channel_width=2 and channel 3 -> 3 beats dropped, drop_count=3, no output valid.
REQ-025 Reset asserted after beat 2 of a 5-beat packet channel 0 -> all valids 0 and drop_count 0; next sop packet routed correctly after release.
